// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: state encodings (also used by the debug unit)
// and the bundle of pipeline-register enables/flushes with its hazard-priority decoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = '0;
  localparam ctl_t CTL_FLOW   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
                                  idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};

  // A wrong-path ID instruction is discarded by the redirect, so the branch outranks load-use.
  function automatic ctl_t decode_ctl(input logic active, input logic dm_req,
                                      input logic dm_ack, input logic br_taken,
                                      input logic load_use);
    ctl_t c;
    c = CTL_FLOW;
    if (!active || (dm_req && !dm_ack)) begin
      c = CTL_FREEZE;
    end else if (br_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating event counter: +1 per clock while inc is high, holds at all-ones, never wraps.
// Count is visible one cycle after the incrementing edge; no backpressure.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use/branch/data-memory hazards with debug run/step into
// per-register enables and flushes (combinational, same cycle); halted and counters are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             dm_req,
  input  logic             dm_ack,
  input  logic             dbg_run,
  input  logic             dbg_step,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state;
  logic   ret_halt;
  logic   step_q;
  logic   step_rise;
  logic   active;
  logic   mem_stall;
  ctl_t   ctl;

  // MWAIT only evaluates the pipe on the cycle the memory completes.
  assign active    = (state == ST_RUN) || (state == ST_STEP) || ((state == ST_MWAIT) && dm_ack);
  assign mem_stall = active && dm_req && !dm_ack;
  assign step_rise = dbg_step && !step_q;

  assign ctl = rstn ? decode_ctl(active, dm_req, dm_ack, br_taken, load_use) : CTL_FREEZE;

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_en    = ctl.idex_en;
  assign idex_flush = ctl.idex_flush;
  assign exmem_en   = ctl.exmem_en;
  assign memwb_en   = ctl.memwb_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_RUN;
      ret_halt <= 1'b0;
      step_q   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      step_q <= dbg_step;
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MWAIT;
            ret_halt <= 1'b0;
            halted   <= 1'b0;
          end else if (!dbg_run) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            halted <= 1'b0;
          end
        end
        ST_MWAIT: begin
          if (dm_ack && (ret_halt || !dbg_run)) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (dm_ack) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end else begin
            halted <= 1'b0;
          end
        end
        ST_HALT: begin
          if (dbg_run) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end else if (step_rise) begin
            state  <= ST_STEP;
            halted <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end
        ST_STEP: begin
          // A step that stalls on memory must come back to HALT, not RUN.
          if (mem_stall) begin
            state    <= ST_MWAIT;
            ret_halt <= 1'b1;
            halted   <= 1'b0;
          end else begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (!ctl.pc_en && (state != ST_HALT)),
    .q    (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (ctl.ifid_flush),
    .q    (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded bench for pipe_ctrl: directed hazard/debug scenarios then random stimulus,
// checked against a mode-based reference model; a narrow-counter instance checks saturation.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, load_use, br_taken, dm_req, dm_ack, dbg_run, dbg_step;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic n_pc_en, n_ifid_en, n_ifid_flush, n_idex_en, n_idex_flush, n_exmem_en, n_memwb_en, n_halted;
  logic [3:0] n_stall_cnt, n_flush_cnt;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .load_use(load_use), .br_taken(br_taken), .dm_req(dm_req),
    .dm_ack(dm_ack), .dbg_run(dbg_run), .dbg_step(dbg_step), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rstn(rstn), .load_use(load_use), .br_taken(br_taken), .dm_req(dm_req),
    .dm_ack(dm_ack), .dbg_run(dbg_run), .dbg_step(dbg_step), .pc_en(n_pc_en),
    .ifid_en(n_ifid_en), .ifid_flush(n_ifid_flush), .idex_en(n_idex_en),
    .idex_flush(n_idex_flush), .exmem_en(n_exmem_en), .memwb_en(n_memwb_en),
    .halted(n_halted), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  typedef struct packed {
    logic [7:0]  ctl;   // {pc,ifid,ifid_flush,idex,idex_flush,exmem,memwb,halted}
    logic [31:0] st;
    logic [31:0] fl;
    logic [3:0]  st4;
    logic [3:0]  fl4;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: which debug/memory situation the core is in, plus plain event tallies.
  bit     m_halt, m_wait, m_step, m_wait_halt, m_prev_step;
  longint m_stall, m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                      memwb_en, halted}, {24'd0, e.ctl});
        check("stall_cnt", stall_cnt, e.st);
        check("flush_cnt", flush_cnt, e.fl);
        check("stall_cnt_w4", {28'd0, n_stall_cnt}, {28'd0, e.st4});
        check("flush_cnt_w4", {28'd0, n_flush_cnt}, {28'd0, e.fl4});
        check("ctl_w4", {24'd0, n_pc_en, n_ifid_en, n_ifid_flush, n_idex_en, n_idex_flush,
                         n_exmem_en, n_memwb_en, n_halted}, {24'd0, e.ctl});
      end
    end
  end

  task automatic cyc(input bit rst, input bit lu, input bit br, input bit req, input bit ack,
                     input bit run, input bit step);
    exp_t     e;
    bit       ev, ms;
    bit [6:0] c;
    @(posedge clk);
    #1;
    rstn = rst; load_use = lu; br_taken = br; dm_req = req; dm_ack = ack;
    dbg_run = run; dbg_step = step;
    if (!rst) begin
      e = '0;
      exp_q.push_back(e);
      m_halt = 0; m_wait = 0; m_step = 0; m_wait_halt = 0; m_prev_step = 0;
      m_stall = 0; m_flush = 0;
      return;
    end
    ev = !m_halt && (!m_wait || ack);
    ms = ev && req && !ack;
    if (!ev || ms)  c = 7'b0000000;
    else if (br)    c = 7'b1111111;
    else if (lu)    c = 7'b0001111;
    else            c = 7'b1101011;
    e.ctl = {c, m_halt};
    e.st  = m_stall[31:0];
    e.fl  = m_flush[31:0];
    e.st4 = (m_stall > 15) ? 4'd15 : 4'(m_stall);
    e.fl4 = (m_flush > 15) ? 4'd15 : 4'(m_flush);
    exp_q.push_back(e);
    if (!c[6] && !m_halt) m_stall++;
    if (c[4]) m_flush++;
    if (m_halt) begin
      if (run) m_halt = 0;
      else if (step && !m_prev_step) begin m_halt = 0; m_step = 1; end
    end else if (m_wait) begin
      if (ack) begin
        m_wait = 0;
        if (m_wait_halt || !run) m_halt = 1;
      end
    end else if (m_step) begin
      m_step = 0;
      if (ms) begin m_wait = 1; m_wait_halt = 1; end
      else m_halt = 1;
    end else begin
      if (ms) begin m_wait = 1; m_wait_halt = 0; end
      else if (!run) m_halt = 1;
    end
    m_prev_step = step;
  endtask

  initial begin
    rstn = 0; load_use = 0; br_taken = 0; dm_req = 0; dm_ack = 0; dbg_run = 1; dbg_step = 0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    // load-use bubble, then branch beating load-use
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    // three-cycle memory wait then ack
    repeat (3) cyc(1, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    // halt, then a held step request yields one step
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    // step that stalls on memory returns to HALT
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    // reset pulse in the middle of a stepped memory wait
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    // long load-use run saturates the narrow counter
    repeat (20) cyc(1, 1, 0, 0, 0, 1, 0);
    repeat (3) cyc(1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 200) != 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
          ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 8) != 0,
          ($urandom % 4) == 0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
